// File: rtl/boreal_status_poller.sv
// Periodic status poller: on every scan tick it reads six 16-bit status
// registers, freezes them in a snapshot and streams them out as a byte frame.
// Frame: 0xA5, seq (frame_count[7:0]), 6 x {MSB, LSB} [, XOR checksum].
// Optional feature macro: BOREAL_POLL_CSUM_EN (appends the checksum byte).
// Ports:
//   clk, rst_n (async, active-low)   clock and reset
//   enable                           high enables periodic scanning
//   clr_overrun                      pulse clearing the overrun flag
//   addr[2:0], rd_en, rd_data[15:0]  status register file read port
//   tx_data[7:0], tx_valid, tx_ready byte stream with valid/ready handshake
//   busy                             high whenever the FSM is not idle
//   frame_count[15:0]                number of completed frames (wraps)
//   overrun                          sticky: a scan tick arrived while busy
module boreal_status_poller #(
    parameter int POLL_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        clr_overrun,
    output logic [2:0]  addr,
    output logic        rd_en,
    input  logic [15:0] rd_data,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic [15:0] frame_count,
    output logic        overrun
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_CAP  = 3'd2,
        TX_SYNC = 3'd3,
        TX_SEQ  = 3'd4,
`ifdef BOREAL_POLL_CSUM_EN
        TX_CSUM = 3'd6,
`endif
        TX_DATA = 3'd5
    } state_t;

    state_t      state;
    logic [15:0] cnt;
    logic        scan_tick;
    logic [2:0]  index;
    logic [3:0]  bidx;
    logic [15:0] snap [6];
    logic [3:0]  nxt;
    logic [2:0]  nsel;
    logic [7:0]  next_byte;
    logic        accept;
`ifdef BOREAL_POLL_CSUM_EN
    logic [7:0]  csum;
`endif

    // Tick counter: free-runs only while enabled, so the first tick lands
    // POLL_DIV cycles after enable is first seen high.
    assign scan_tick = enable && (cnt == 16'(POLL_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!enable || scan_tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 16'd1;
        end
    end

    // Byte following data byte bidx: even -> MSB, odd -> LSB of snap[k/2].
    assign accept = tx_valid && tx_ready;
    assign nxt    = bidx + 4'd1;
    assign nsel   = (nxt[3:1] > 3'd5) ? 3'd0 : nxt[3:1];

    always_comb begin
        next_byte = nxt[0] ? snap[nsel][7:0] : snap[nsel][15:8];
    end

    // Tick dropped while busy; a set in the same cycle beats a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else if (scan_tick && busy) begin
            overrun <= 1'b1;
        end else if (clr_overrun) begin
            overrun <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            index       <= '0;
            bidx        <= '0;
            addr        <= '0;
            rd_en       <= 1'b0;
            tx_data     <= '0;
            tx_valid    <= 1'b0;
            busy        <= 1'b0;
            frame_count <= '0;
            for (int i = 0; i < 6; i++) snap[i] <= '0;
`ifdef BOREAL_POLL_CSUM_EN
            csum        <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (scan_tick) begin
                        state <= RD_REQ;
                        busy  <= 1'b1;
                        index <= '0;
                        addr  <= '0;
                        rd_en <= 1'b1;
                    end
                end
                RD_REQ: begin
                    rd_en <= 1'b0;
                    state <= RD_CAP;
                end
                RD_CAP: begin
                    snap[index] <= rd_data;
                    if (index == 3'd5) begin
                        state    <= TX_SYNC;
                        tx_valid <= 1'b1;
                        tx_data  <= 8'hA5;
                    end else begin
                        index <= index + 3'd1;
                        addr  <= index + 3'd1;
                        rd_en <= 1'b1;
                        state <= RD_REQ;
                    end
                end
                TX_SYNC: begin
                    if (accept) begin
                        tx_data <= frame_count[7:0];
                        state   <= TX_SEQ;
                    end
                end
                TX_SEQ: begin
                    if (accept) begin
                        tx_data <= snap[0][15:8];
                        bidx    <= '0;
                        state   <= TX_DATA;
`ifdef BOREAL_POLL_CSUM_EN
                        csum    <= tx_data;
`endif
                    end
                end
                TX_DATA: begin
                    if (accept) begin
                        if (bidx == 4'd11) begin
`ifdef BOREAL_POLL_CSUM_EN
                            tx_data <= csum ^ tx_data;
                            state   <= TX_CSUM;
`else
                            tx_valid    <= 1'b0;
                            busy        <= 1'b0;
                            frame_count <= frame_count + 16'd1;
                            state       <= IDLE;
`endif
                        end else begin
                            tx_data <= next_byte;
                            bidx    <= nxt;
`ifdef BOREAL_POLL_CSUM_EN
                            csum    <= csum ^ tx_data;
`endif
                        end
                    end
                end
`ifdef BOREAL_POLL_CSUM_EN
                TX_CSUM: begin
                    if (accept) begin
                        tx_valid    <= 1'b0;
                        busy        <= 1'b0;
                        frame_count <= frame_count + 16'd1;
                        state       <= IDLE;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_boreal_status_poller.sv
// Directed bench for boreal_status_poller (POLL_DIV=32).
// Checks reset, frame contents, stalls, overrun and mid-frame reset.
module tb_boreal_status_poller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        clr_overrun = 1'b0;
    logic [2:0]  addr;
    logic        rd_en;
    logic [15:0] rd_data;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        busy;
    logic [15:0] frame_count;
    logic        overrun;

    int ntests = 0;
    int nfail = 0;
    int mode = 0;
    int cyc = 0;

    logic [15:0] regs [6];
    logic [7:0]  got [$];
    logic [7:0]  exp_q [$];
    logic [2:0]  addrs [$];
    logic        pv = 1'b0;
    logic        pr = 1'b0;
    logic [7:0]  pd = 8'h00;

    boreal_status_poller #(.POLL_DIV(32)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .clr_overrun(clr_overrun), .addr(addr), .rd_en(rd_en),
        .rd_data(rd_data), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .busy(busy), .frame_count(frame_count),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Register file: data valid the cycle after the rd_en cycle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_data <= 16'h0000;
        else if (rd_en) rd_data <= regs[addr];
    end

    always @(negedge clk) begin
        cyc++;
        case (mode)
            0: tx_ready = 1'b1;
            1: tx_ready = (cyc % 3 == 0);
            default: tx_ready = 1'b0;
        endcase
    end

    // Collect accepted bytes / read addresses; check stall stability.
    always @(posedge clk) begin
        if (rst_n) begin
            if (tx_valid && tx_ready) got.push_back(tx_data);
            if (rd_en) addrs.push_back(addr);
            if (pv && !pr) begin
                ntests++;
                if (tx_valid !== 1'b1 || tx_data !== pd) begin
                    nfail++;
                    $display("FAIL stall_stable: valid=%b data=%h want valid=1 data=%h",
                             tx_valid, tx_data, pd);
                end
            end
            pv = tx_valid;
            pr = tx_ready;
            pd = tx_data;
        end else begin
            pv = 1'b0;
        end
    end

    task automatic build_exp(input logic [7:0] seq);
        logic [7:0] cs;
        exp_q = {};
        exp_q.push_back(8'hA5);
        exp_q.push_back(seq);
        cs = seq;
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(regs[i][15:8]);
            exp_q.push_back(regs[i][7:0]);
            cs = cs ^ regs[i][15:8] ^ regs[i][7:0];
        end
`ifdef BOREAL_POLL_CSUM_EN
        exp_q.push_back(cs);
`endif
    endtask

    task automatic wait_fc(input logic [15:0] target, input string name);
        int k;
        k = 0;
        while (frame_count !== target && k < 2000) begin
            @(negedge clk);
            k++;
        end
        ntests++;
        if (frame_count !== target) begin
            nfail++;
            $display("FAIL %s_timeout: frame_count=%h want %h", name, frame_count, target);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        ntests++;
        if ({addr, rd_en, tx_data, tx_valid, busy, frame_count, overrun} !== 31'd0) begin
            nfail++;
            $display("FAIL reset_outputs: addr=%h rd_en=%b tx=%h v=%b busy=%b fc=%h ov=%b want all 0",
                     addr, rd_en, tx_data, tx_valid, busy, frame_count, overrun);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_frame();
        int n;
        regs = '{16'h1234, 16'hFFEE, 16'h0005, 16'h0010, 16'h0100, 16'h8000};
        got = {};
        addrs = {};
        mode = 0;
        @(negedge clk);
        enable = 1'b1;
        n = 0;
        while (n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (rd_en) break;
        end
        enable = 1'b0;
        ntests++;
        if (n !== 32) begin
            nfail++;
            $display("FAIL first_rd_en: cycles=%0d want 32", n);
        end
        wait_fc(16'd1, "frame");
        repeat (80) @(negedge clk);
        ntests++;
        if (busy !== 1'b0 || frame_count !== 16'd1) begin
            nfail++;
            $display("FAIL no_tick_after_disable: busy=%b fc=%h want 0/0001", busy, frame_count);
        end
        ntests++;
        if (overrun !== 1'b0) begin
            nfail++;
            $display("FAIL frame_overrun: got %b want 0", overrun);
        end
        ntests++;
        if (addrs.size() != 6) begin
            nfail++;
            $display("FAIL read_count: got %0d want 6", addrs.size());
        end
        for (int i = 0; i < addrs.size() && i < 6; i++) begin
            ntests++;
            if (addrs[i] !== 3'(i)) begin
                nfail++;
                $display("FAIL read_addr[%0d]: got %0d want %0d", i, addrs[i], i);
            end
        end
        exp_q = {8'hA5, 8'h00, 8'h12, 8'h34, 8'hFF, 8'hEE, 8'h00, 8'h05,
                 8'h00, 8'h10, 8'h01, 8'h00, 8'h80, 8'h00};
`ifdef BOREAL_POLL_CSUM_EN
        exp_q.push_back(8'hA3);
`endif
        ntests++;
        if (got.size() != exp_q.size()) begin
            nfail++;
            $display("FAIL frame_len: got %0d want %0d", got.size(), exp_q.size());
        end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            ntests++;
            if (got[i] !== exp_q[i]) begin
                nfail++;
                $display("FAIL frame_byte[%0d]: got %h want %h", i, got[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_stall();
        int k;
        got = {};
        mode = 1;
        build_exp(8'h01);
        @(negedge clk);
        enable = 1'b1;
        k = 0;
        while (!rd_en && k < 100) begin
            @(negedge clk);
            k++;
        end
        enable = 1'b0;
        k = 0;
        while (!tx_valid && k < 100) begin
            @(negedge clk);
            k++;
        end
        // Snapshot must be frozen once transmission starts.
        regs = '{16'hDEAD, 16'hBEEF, 16'h0F0F, 16'hF0F0, 16'h5555, 16'hAAAA};
        wait_fc(16'd2, "stall");
        ntests++;
        if (got.size() != exp_q.size()) begin
            nfail++;
            $display("FAIL stall_len: got %0d want %0d", got.size(), exp_q.size());
        end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            ntests++;
            if (got[i] !== exp_q[i]) begin
                nfail++;
                $display("FAIL stall_byte[%0d]: got %h want %h", i, got[i], exp_q[i]);
            end
        end
        mode = 0;
    endtask

    task automatic test_overrun();
        got = {};
        build_exp(8'h02);
        mode = 2;
        @(negedge clk);
        enable = 1'b1;
        for (int n = 1; n <= 180; n++) begin
            @(posedge clk);
            #1;
            if (n == 100) begin
                ntests++;
                if (overrun !== 1'b1 || got.size() != 0 || frame_count !== 16'd2) begin
                    nfail++;
                    $display("FAIL overrun_set: ov=%b bytes=%0d fc=%h want 1/0/0002",
                             overrun, got.size(), frame_count);
                end
            end
            if (n == 129) begin
                ntests++;
                if (overrun !== 1'b1) begin
                    nfail++;
                    $display("FAIL set_beats_clear: got %b want 1", overrun);
                end
            end
            if (n == 142) begin
                ntests++;
                if (overrun !== 1'b0) begin
                    nfail++;
                    $display("FAIL overrun_clear: got %b want 0", overrun);
                end
            end
            if (n == 170) begin
                ntests++;
                if (overrun !== 1'b1) begin
                    nfail++;
                    $display("FAIL overrun_reset: got %b want 1", overrun);
                end
            end
            #1;
            clr_overrun = (n == 127) || (n == 140);
        end
        clr_overrun = 1'b0;
        enable = 1'b0;
        mode = 0;
        wait_fc(16'd3, "overrun");
        repeat (40) @(negedge clk);
        ntests++;
        if (got.size() != exp_q.size() || frame_count !== 16'd3) begin
            nfail++;
            $display("FAIL one_frame_only: bytes=%0d fc=%h want %0d/0003",
                     got.size(), frame_count, exp_q.size());
        end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            ntests++;
            if (got[i] !== exp_q[i]) begin
                nfail++;
                $display("FAIL overrun_byte[%0d]: got %h want %h", i, got[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int k;
        got = {};
        mode = 1;
        @(negedge clk);
        enable = 1'b1;
        k = 0;
        while (!rd_en && k < 100) begin
            @(negedge clk);
            k++;
        end
        enable = 1'b0;
        k = 0;
        while (got.size() < 7 && k < 500) begin
            @(negedge clk);
            k++;
        end
        ntests++;
        if (got.size() != 7 || tx_valid !== 1'b1) begin
            nfail++;
            $display("FAIL reach_byte7: bytes=%0d valid=%b want 7/1", got.size(), tx_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        ntests++;
        if ({addr, rd_en, tx_data, tx_valid, busy, frame_count, overrun} !== 31'd0) begin
            nfail++;
            $display("FAIL mid_reset: addr=%h rd_en=%b tx=%h v=%b busy=%b fc=%h ov=%b want all 0",
                     addr, rd_en, tx_data, tx_valid, busy, frame_count, overrun);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mode = 0;
        got = {};
        build_exp(8'h00);
        @(negedge clk);
        enable = 1'b1;
        k = 0;
        while (!rd_en && k < 100) begin
            @(negedge clk);
            k++;
        end
        enable = 1'b0;
        wait_fc(16'd1, "post_reset");
        ntests++;
        if (got.size() != exp_q.size()) begin
            nfail++;
            $display("FAIL post_reset_len: got %0d want %0d", got.size(), exp_q.size());
        end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            ntests++;
            if (got[i] !== exp_q[i]) begin
                nfail++;
                $display("FAIL post_reset_byte[%0d]: got %h want %h", i, got[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        regs = '{default: 16'h0000};
        test_reset();
        test_frame();
        test_stall();
        test_overrun();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/boreal_status_poller.md
BOREAL_STATUS_POLLER -- requirements
Module: boreal_status_poller

Interface
REQ-001 Parameter POLL_DIV, default 50000: clk cycles between scan starts; legal range 32..65535.
REQ-002 clk  in  1  system clock; all logic on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 enable  in  1  high enables periodic scanning.
REQ-005 clr_overrun  in  1  single-cycle pulse; clears overrun.
REQ-006 addr  out  3  register select driven to the status register file.
REQ-007 rd_en  out  1  read strobe to the status register file; registered output.
REQ-008 rd_data  in  16  register file data; valid the cycle after the rd_en cycle.
REQ-009 tx_data  out  8  outgoing frame byte.
REQ-010 tx_valid  out  1  tx_data holds a byte.
REQ-011 tx_ready  in  1  sink accepts the byte when tx_valid and tx_ready are both high.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 frame_count  out  16  count of fully transmitted frames.
REQ-014 overrun  out  1  sticky flag; a scan tick was dropped.

Function
REQ-015 Tick counter: held at 0 while enable=0; otherwise counts 0..POLL_DIV-1 and wraps, issuing scan_tick on the wrap cycle, so the first tick comes POLL_DIV cycles after enable rises.
REQ-016 FSM states: IDLE, RD_REQ, RD_CAP, TX_SYNC, TX_SEQ, TX_DATA, TX_CSUM (TX_CSUM exists only when the macro of REQ-031 is defined).
REQ-017 IDLE -> RD_REQ on scan_tick; reg index starts at 0.
REQ-018 RD_REQ: addr=index and rd_en=1 for exactly one cycle; next state RD_CAP.
REQ-019 RD_CAP: rd_data is captured into snapshot[index] at the end of the cycle; if index<5, index increments and the FSM returns to RD_REQ; if index=5, the FSM goes to TX_SYNC.
REQ-020 Read phase: addresses 0..5 in order, 12 cycles total; rd_en stays 0 outside RD_REQ; addr holds its last value when rd_en=0.
REQ-021 Frame bytes, in order: 0xA5; seq=frame_count[7:0]; snapshot[0..5] each sent as MSB byte then LSB byte (12 bytes); then the checksum byte if enabled.
REQ-022 Handshake: tx_valid and tx_data stay stable until accepted; tx_valid never drops before acceptance; the next byte may be presented in the cycle after acceptance; tx_valid=0 during IDLE and the read phase.
REQ-023 After the last byte is accepted: frame_count increments (wrapping 0xFFFF->0x0000) and the FSM goes to IDLE in the same cycle.
REQ-024 A scan_tick while busy=1 is dropped and sets overrun; it is never queued.
REQ-025 overrun is cleared by clr_overrun; if set and clear occur in the same cycle, set wins.
REQ-026 enable deasserted mid-scan: the current frame (reads and TX) completes; no new tick follows.
REQ-027 Snapshot is frozen from the end of the read phase through the end of TX; rd_data changes during TX have no effect.
REQ-028 tx_ready held low indefinitely: the FSM stalls with no timeout and no data loss, and overrun accumulates per REQ-024.

Reset
REQ-029 While rst_n=0: FSM=IDLE, tick counter=0, index=0, addr=0, rd_en=0, tx_valid=0, tx_data=0x00, busy=0, frame_count=0, overrun=0, snapshot=0.
REQ-030 Reset mid-frame aborts the frame immediately with no partial completion; after release the first tick comes POLL_DIV cycles after enable is seen high.

Configuration
REQ-031 Macro BOREAL_POLL_CSUM_EN: when defined, the frame is 15 bytes and the final byte is the XOR of seq and the 12 data bytes (0xA5 excluded); when undefined, the frame is 14 bytes, TX_CSUM is absent, and frame_count increments on the last LSB byte.

Verification
REQ-032 POLL_DIV=32, tx_ready=1, CSUM_EN, regs {0x1234,0xFFEE,0x0005,0x0010,0x0100,0x8000} -> first rd_en 32 cycles after enable; frame A5 00 12 34 FF EE 00 05 00 10 01 00 80 00 A3; frame_count=1.
REQ-033 Same stimulus with macro undefined -> 14 bytes ending 80 00; frame_count=1; no A3 byte.
REQ-034 tx_ready toggled 1-of-3 cycles -> identical byte sequence; tx_data/tx_valid stable across every stall; no byte duplicated or skipped.
REQ-035 tx_ready=0 for 100 cycles with POLL_DIV=32 -> overrun=1, only one frame emitted; clr_overrun pulse coincident with a dropped tick -> overrun stays 1.
REQ-036 rst_n pulsed low during byte 7 -> all outputs at reset values within the same cycle; frame_count=0; next frame starts with seq 0x00.
REQ-037 frame_count preloaded by running 65536 frames -> wraps to 0x0000; seq byte 0x00.
